fa_response_checker: RTL

- Consumes the per-cycle full-adder vector stream {A, B, Cin | Cout, Sum} that the stimulus side produces and checks it in hardware.
- Checks each captured Cout/Sum pair against a golden A+B+Cin.
- Counts vectors and mismatches, records the index of the first failure, and compresses the whole stream into a MISR signature.
- Sits beside the fa instance in self-checking benches and BIST wrappers, in place of post-processing the text dump.

---
 rtl/fa_chk_pkg.sv | 18 +
 rtl/fa_misr.sv | 39 +++
 rtl/fa_response_checker.sv | 124 ++++++++++++
 3 files changed

// File: rtl/fa_chk_pkg.sv
// Shared types, constants and the golden full-adder model for the FA response checker.
package fa_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [15:0] DEF_POLY  = 16'h1021;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

  // Golden full adder: {cout, sum} = a + b + cin.
  function automatic logic [1:0] fa_expect(input logic a, input logic b, input logic cin);
    return {1'b0, a} + {1'b0, b} + {1'b0, cin};
  endfunction

endpackage

// File: rtl/fa_misr.sv
// Multiple-input signature register compressing the 5-bit {A,B,Cin,Cout,Sum} stream.
module fa_misr
  import fa_chk_pkg::*;
#(
  parameter int unsigned         MISR_W = 16,
  parameter logic [MISR_W-1:0]   POLY   = MISR_W'(DEF_POLY)
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              clear,
  input  logic              en,
  input  logic [4:0]        din,
  output logic [MISR_W-1:0] sig
);

  logic [MISR_W-1:0] sig_q, sig_d;

  // Next signature: reseed on clear, otherwise shift/feedback/fold-in on enable.
  always_comb begin
    sig_d = sig_q;
    if (clear) begin
      sig_d = '1;
    end else if (en) begin
      sig_d = (sig_q << 1) ^ (sig_q[MISR_W-1] ? POLY : '0) ^ MISR_W'(din);
    end
  end

  // Signature register, seeded to all ones on reset.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      sig_q <= '1;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/fa_response_checker.sv
// Hardware checker for a full-adder vector stream: golden compare, counters,
// first-failure index and MISR signature over a run of VEC_COUNT vectors.
module fa_response_checker
  import fa_chk_pkg::*;
#(
  parameter int unsigned       VEC_COUNT = 20,
  parameter int unsigned       CNT_W     = 16,
  parameter int unsigned       MISR_W    = 16,
  parameter logic [MISR_W-1:0] POLY      = MISR_W'(DEF_POLY)
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic              Vld,
  input  logic              A,
  input  logic              B,
  input  logic              Cin,
  input  logic              Cout,
  input  logic              Sum,
  output logic              Busy,
  output logic              Done,
  output logic              Pass,
  output logic              ErrFlag,
  output logic [CNT_W-1:0]  VecCnt,
  output logic [CNT_W-1:0]  ErrCnt,
  output logic [CNT_W-1:0]  FirstErrIdx,
  output logic [MISR_W-1:0] Signature
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] first_err_idx_q, first_err_idx_d;
  logic             err_flag_q, err_flag_d;

  logic             start_run;
  logic             accept;
  logic             last_vec;
  logic             mismatch;

  assign start_run = Start && ((state_q == IDLE) || (state_q == DONE));
  assign accept    = Vld && (state_q == RUN);
  assign last_vec  = (vec_cnt_q == CNT_W'(VEC_COUNT - 1));
  assign mismatch  = ({Cout, Sum} != fa_expect(A, B, Cin));

  // State register.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: Start arms from IDLE/DONE; the last accepted vector ends the run.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Start) state_d = RUN;
      RUN:     if (accept && last_vec) state_d = DONE;
      DONE:    if (Start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Counter/compare datapath: cleared on run entry, updated only on accepts.
  always_comb begin
    vec_cnt_d       = vec_cnt_q;
    err_cnt_d       = err_cnt_q;
    first_err_idx_d = first_err_idx_q;
    err_flag_d      = 1'b0;
    if (start_run) begin
      vec_cnt_d       = '0;
      err_cnt_d       = '0;
      first_err_idx_d = '0;
    end else if (accept) begin
      vec_cnt_d = vec_cnt_q + CNT_W'(1);
      if (mismatch) begin
        err_flag_d = 1'b1;
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
        if (err_cnt_q == '0) first_err_idx_d = vec_cnt_q;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      vec_cnt_q       <= '0;
      err_cnt_q       <= '0;
      first_err_idx_q <= '0;
      err_flag_q      <= 1'b0;
    end else begin
      vec_cnt_q       <= vec_cnt_d;
      err_cnt_q       <= err_cnt_d;
      first_err_idx_q <= first_err_idx_d;
      err_flag_q      <= err_flag_d;
    end
  end

  // Output decode from registered state.
  always_comb begin
    Busy        = (state_q == RUN);
    Done        = (state_q == DONE);
    Pass        = (state_q == DONE) && (err_cnt_q == '0);
    ErrFlag     = err_flag_q;
    VecCnt      = vec_cnt_q;
    ErrCnt      = err_cnt_q;
    FirstErrIdx = first_err_idx_q;
  end

  fa_misr #(
    .MISR_W (MISR_W),
    .POLY   (POLY)
  ) u_misr (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .clear   (start_run),
    .en      (accept),
    .din     ({A, B, Cin, Cout, Sum}),
    .sig     (Signature)
  );

endmodule
